sm_frame_ctrl: RTL and testbench
================================

# sm_frame_ctrl

Frame sequencer that feeds the QPSK signal-mapping datapath (`SM`). Once started, it can emit a fixed pilot preamble. It then pulls a serial bit stream through a valid/ready handshake and packs bit pairs into 2-bit symbols for `SM.din`. A frame is exactly `FRAME_SYMS` payload symbols, and the block reports frame completion with a single-cycle pulse.

## Interface
- `FRAME_SYMS`, default 512: payload symbols per frame; must be ≥1.
- `PRE_SYMS`, default 8: pilot symbols per frame; must be ≥1; used only with `SM_FRAME_PILOT_EN`.
- `IW`, default `$clog2(FRAME_SYMS)`: width of `sym_idx`; must be ≥1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `bit_in`  in  1  serial payload bit.
- `bit_valid`  in  1  `bit_in` is valid.
- `bit_ready`  out  1  block accepts a bit this cycle; combinational, `state==PAYLOAD`.
- `sym_out`  out  2  symbol to `SM.din`; registered; holds its last value between valids.
- `sym_valid`  out  1  `sym_out` is new this cycle; registered, one-cycle pulse.
- `sym_pilot`  out  1  current valid symbol is a pilot symbol; registered.
- `sym_idx`  out  IW  payload index (0..FRAME_SYMS-1) of current valid symbol; 0 for pilots.
- `busy`  out  1  state is not IDLE; registered.
- `done`  out  1  one-cycle pulse after the last payload symbol.

## Operation
- States: IDLE, PILOT, PAYLOAD, DONE. Reset state is IDLE.
- IDLE, `start`=1: go to PILOT, or directly to PAYLOAD without the macro. `busy` rises at the same edge.
- PILOT emits one symbol per cycle from a pilot counter (0..PRE_SYMS-1):
  - `sym_out` = 2'b11 for even counts, 2'b00 for odd counts.
  - `sym_valid`=1, `sym_pilot`=1.
  - After the symbol with count PRE_SYMS-1, go to PAYLOAD.
- PAYLOAD handles bits on handshake (`bit_valid && bit_ready`):
  - A half flag toggles on each accepted bit.
  - First accepted bit is stored as the MSB.
  - Second accepted bit loads `sym_out`={MSB, bit}, `sym_valid`=1, `sym_pilot`=0, `sym_idx`=payload count. The payload count then increments.
- Last symbol: the edge that produces payload index FRAME_SYMS-1 also moves the state to DONE.
- DONE lasts one cycle with `done`=1, `busy`=1. It then returns to IDLE, where `busy`=0.
- `start` outside IDLE is ignored.
- `bit_valid` outside PAYLOAD is ignored; no bit is consumed because `bit_ready`=0.
- `rst` overrides everything, including a same-cycle `start` or handshake:
  - All state returns to IDLE and counters clear.
  - Any held half symbol is discarded.
- Reset values: `sym_out`=0, `sym_valid`=0, `sym_pilot`=0, `sym_idx`=0, `busy`=0, `done`=0, `bit_ready`=0.

## Timing
- `start` sampled at edge k:
  - With the macro, the first pilot `sym_valid` is high after edge k+1.
  - Pilots occupy cycles after edges k+1..k+PRE_SYMS.
  - `bit_ready` is high from the cycle after edge k+PRE_SYMS.
- Without the macro, `bit_ready` is high from the cycle after edge k.
- Symbol latency is 1 cycle: the symbol is valid in the cycle after the edge that accepted its second bit.
- With `bit_valid` held high, payload symbols appear every 2nd cycle.
- With continuous bits, a frame takes 2·FRAME_SYMS payload cycles.
- `done` is high in the cycle after the edge that accepted the final bit.
- That cycle is also the final symbol's valid cycle, so `done` and the last `sym_valid` coincide.
- `bit_ready` is low in the `done` cycle.
- `SM` is combinational, so I/Q follows `sym_out` in the same cycle.

## Configuration
- `SM_FRAME_PILOT_EN` defined:
  - PILOT state is compiled in.
  - Each frame starts with PRE_SYMS alternating 2'b11/2'b00 pilot symbols.
- `SM_FRAME_PILOT_EN` undefined:
  - PILOT state, pilot counter and `PRE_SYMS` logic are removed.
  - IDLE goes directly to PAYLOAD.
  - `sym_pilot` is tied to 0.

## Test plan
All cases use FRAME_SYMS=512 and PRE_SYMS=8.
- Reset: hold `rst` for 3 cycles with `start`=1 and `bit_valid`=1 → all outputs 0, `bit_ready`=0, no `sym_valid`.
- Full frame with macro, `bit_valid`=1 continuously, bits 1,0 repeating:
  - 8 pilot symbols 3,0,3,0,3,0,3,0 with `sym_pilot`=1.
  - Then 512 symbols of 2'b10 with `sym_idx` 0..511.
  - `done` is a single pulse coinciding with `sym_idx`=511.
  - `busy` is high for 8+1024+1 cycles.
- Gapped input: `bit_valid` toggled every cycle with bits 0,1,1,1 → symbols 2'b01 then 2'b11, each valid exactly 1 cycle after its second accepted bit.
- Ignored inputs:
  - `start` pulsed mid-frame → frame length unchanged, no restart.
  - `bit_valid`=1 in IDLE → no symbol produced, and first frame symbol built only from bits after `bit_ready` rises.
- Mid-frame reset: `rst` after 3 payload bits accepted, then a new `start` with bits 0,0 → first payload `sym_out`=2'b00 at `sym_idx`=0; the stale half bit is not used.
- Without macro: `start` → `bit_ready` high in the next cycle, no pilot symbols, `sym_pilot` never 1, frame of 1024 bits gives a `done` pulse.

Source files
------------

// File: rtl/sm_frame_ctrl.sv
// sm_frame_ctrl: frame sequencer that feeds the QPSK signal mapper.
// It accepts a start request and can emit an alternating pilot preamble.
// It then pulls a serial bit stream through a valid/ready handshake and
// packs bit pairs into 2-bit symbols. A frame is FRAME_SYMS payload symbols
// and ends with a one-cycle done pulse.
//
// Optional feature macro: SM_FRAME_PILOT_EN
//   defined   -> PRE_SYMS pilot symbols (11,00,11,...) precede each payload
//   undefined -> IDLE goes straight to PAYLOAD and sym_pilot_o is tied to 0
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      frame request, sampled only in IDLE
//   bit_in_i     serial payload bit
//   bit_valid_i  bit_in_i is valid
//   bit_ready_o  combinational; high while in PAYLOAD
//   sym_out_o    registered symbol to the mapper; holds between valids
//   sym_valid_o  registered one-cycle pulse when sym_out_o is new
//   sym_pilot_o  registered; current valid symbol is a pilot
//   sym_idx_o    registered payload index of current symbol (0 for pilots)
//   busy_o       registered; state is not IDLE
//   done_o       registered one-cycle pulse with the last payload symbol
module sm_frame_ctrl #(
    parameter int unsigned FRAME_SYMS = 512,
    parameter int unsigned PRE_SYMS   = 8,
    parameter int unsigned IW         = $clog2(FRAME_SYMS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          bit_in_i,
    input  logic          bit_valid_i,
    output logic          bit_ready_o,
    output logic [1:0]    sym_out_o,
    output logic          sym_valid_o,
    output logic          sym_pilot_o,
    output logic [IW-1:0] sym_idx_o,
    output logic          busy_o,
    output logic          done_o
);

    // Reject parameter sets that would give zero-width counters.
    if (FRAME_SYMS < 1 || PRE_SYMS < 1 || IW < 1) begin : g_cfg_err
        $error("sm_frame_ctrl: FRAME_SYMS, PRE_SYMS and IW must all be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PILOT   = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          half_q, half_d;
    logic          msb_q, msb_d;
    logic [IW-1:0] pay_cnt_q, pay_cnt_d;
    logic [1:0]    sym_out_q, sym_out_d;
    logic          sym_valid_q, sym_valid_d;
    logic [IW-1:0] sym_idx_q, sym_idx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          hs_c;
    logic          last_sym_c;

`ifdef SM_FRAME_PILOT_EN
    localparam int unsigned PW = (PRE_SYMS > 1) ? $clog2(PRE_SYMS) : 1;

    logic [PW-1:0] pil_cnt_q, pil_cnt_d;
    logic          sym_pilot_q, sym_pilot_d;
    logic          pil_last_c;

    assign pil_last_c  = (pil_cnt_q == PW'(PRE_SYMS - 1));
    assign sym_pilot_o = sym_pilot_q;
`else
    assign sym_pilot_o = 1'b0;
`endif

    // Handshake and final-symbol detection; the second bit of the last pair closes the frame.
    assign hs_c        = bit_valid_i && (state_q == ST_PAYLOAD);
    assign last_sym_c  = hs_c && half_q && (pay_cnt_q == IW'(FRAME_SYMS - 1));
    assign bit_ready_o = (state_q == ST_PAYLOAD);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
`ifdef SM_FRAME_PILOT_EN
                    state_d = ST_PILOT;
`else
                    state_d = ST_PAYLOAD;
`endif
                end
            end
`ifdef SM_FRAME_PILOT_EN
            ST_PILOT: begin
                if (pil_last_c) begin
                    state_d = ST_PAYLOAD;
                end
            end
`endif
            ST_PAYLOAD: begin
                if (last_sym_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values; all registered below.
    always_comb begin
        half_d      = half_q;
        msb_d       = msb_q;
        pay_cnt_d   = pay_cnt_q;
        sym_out_d   = sym_out_q;
        sym_valid_d = 1'b0;
        sym_idx_d   = sym_idx_q;
        busy_d      = (state_d != ST_IDLE);
        done_d      = last_sym_c;
`ifdef SM_FRAME_PILOT_EN
        pil_cnt_d   = pil_cnt_q;
        sym_pilot_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                half_d    = 1'b0;
                pay_cnt_d = '0;
`ifdef SM_FRAME_PILOT_EN
                pil_cnt_d = '0;
`endif
            end
`ifdef SM_FRAME_PILOT_EN
            ST_PILOT: begin
                // Even counts send 11, odd counts send 00.
                sym_out_d   = pil_cnt_q[0] ? 2'b00 : 2'b11;
                sym_valid_d = 1'b1;
                sym_pilot_d = 1'b1;
                sym_idx_d   = '0;
                pil_cnt_d   = pil_cnt_q + PW'(1);
            end
`endif
            ST_PAYLOAD: begin
                if (hs_c) begin
                    half_d = ~half_q;
                    if (!half_q) begin
                        msb_d = bit_in_i;
                    end else begin
                        sym_out_d   = {msb_q, bit_in_i};
                        sym_valid_d = 1'b1;
                        sym_idx_d   = pay_cnt_q;
                        pay_cnt_d   = pay_cnt_q + IW'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            half_q      <= 1'b0;
            msb_q       <= 1'b0;
            pay_cnt_q   <= '0;
            sym_out_q   <= 2'b00;
            sym_valid_q <= 1'b0;
            sym_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SM_FRAME_PILOT_EN
            pil_cnt_q   <= '0;
            sym_pilot_q <= 1'b0;
`endif
        end else begin
            half_q      <= half_d;
            msb_q       <= msb_d;
            pay_cnt_q   <= pay_cnt_d;
            sym_out_q   <= sym_out_d;
            sym_valid_q <= sym_valid_d;
            sym_idx_q   <= sym_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SM_FRAME_PILOT_EN
            pil_cnt_q   <= pil_cnt_d;
            sym_pilot_q <= sym_pilot_d;
`endif
        end
    end

    assign sym_out_o   = sym_out_q;
    assign sym_valid_o = sym_valid_q;
    assign sym_idx_o   = sym_idx_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_sm_frame_ctrl.sv
// Directed self-checking bench for sm_frame_ctrl (FRAME_SYMS=512, PRE_SYMS=8).
// Works with and without SM_FRAME_PILOT_EN defined.
module tb_sm_frame_ctrl;

    localparam int FS      = 512;
    localparam int PS      = 8;
    localparam int IW      = $clog2(FS);
    localparam int TIMEOUT = 5000;
`ifdef SM_FRAME_PILOT_EN
    localparam int   NPIL = PS;
    localparam logic RDY0 = 1'b0;
`else
    localparam int   NPIL = 0;
    localparam logic RDY0 = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          bit_in_i;
    logic          bit_valid_i;
    logic          bit_ready_o;
    logic [1:0]    sym_out_o;
    logic          sym_valid_o;
    logic          sym_pilot_o;
    logic [IW-1:0] sym_idx_o;
    logic          busy_o;
    logic          done_o;

    sm_frame_ctrl #(
        .FRAME_SYMS (FS),
        .PRE_SYMS   (PS),
        .IW         (IW)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .bit_in_i    (bit_in_i),
        .bit_valid_i (bit_valid_i),
        .bit_ready_o (bit_ready_o),
        .sym_out_o   (sym_out_o),
        .sym_valid_o (sym_valid_o),
        .sym_pilot_o (sym_pilot_o),
        .sym_idx_o   (sym_idx_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    sym;
        logic          pil;
        logic [IW-1:0] idx;
        logic          dn;
        int            cyc;
    } ev_t;

    // Monitor state: written only by the negedge monitor.
    ev_t ev_q[$];
    ev_t mon_e;
    int  cyc       = 0;
    int  busy_cnt  = 0;
    int  done_cnt  = 0;
    int  pilot_cnt = 0;

    // Bench state: written only by the main process.
    logic bits_q[$];
    int   exp_cyc_q[$];
    int   errors = 0;
    int   checks = 0;
    int   q0, b0, d0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (busy_o)      busy_cnt  = busy_cnt + 1;
        if (done_o)      done_cnt  = done_cnt + 1;
        if (sym_pilot_o) pilot_cnt = pilot_cnt + 1;
        if (sym_valid_o) begin
            mon_e.sym = sym_out_o;
            mon_e.pil = sym_pilot_o;
            mon_e.idx = sym_idx_o;
            mon_e.dn  = done_o;
            mon_e.cyc = cyc;
            ev_q.push_back(mon_e);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a frame and feed bits_q until done (or stop_bits accepted).
    // gap toggles bit_valid every cycle; mid_start pulses start at that loop cycle.
    task automatic run_frame(input bit gap, input int stop_bits, input int mid_start);
        int idx = 0;
        int n   = 0;
        bit hs;
        exp_cyc_q.delete();
        start_i     = 1'b1;
        bit_valid_i = 1'b1;
        bit_in_i    = bits_q[0];
        step();
        start_i = 1'b0;
        chk("busy_after_start", busy_o, 1);
        chk("ready_after_start", bit_ready_o, RDY0);
        while (n < TIMEOUT) begin
            if (done_o) break;
            if (stop_bits > 0 && idx >= stop_bits) break;
            bit_valid_i = gap ? (n % 2 == 0) : 1'b1;
            bit_in_i    = (idx < bits_q.size()) ? bits_q[idx] : 1'b0;
            start_i     = (n == mid_start);
            hs          = bit_valid_i && bit_ready_o;
            step();
            start_i = 1'b0;
            n = n + 1;
            if (hs) begin
                idx = idx + 1;
                // The symbol completed at this edge must be valid in the next cycle.
                if (idx % 2 == 0) exp_cyc_q.push_back(cyc + 1);
            end
        end
        if (n >= TIMEOUT) chk("frame_timeout", 1, 0);
        if (done_o) begin
            chk("ready_low_in_done", bit_ready_o, 0);
            chk("valid_with_done", sym_valid_o, 1);
        end
        bit_valid_i = 1'b0;
    endtask

    task automatic check_frame(input string nm, input int first);
        int   bad_pil = 0, bad_sym = 0, bad_idx = 0, bad_lat = 0, n_dn = 0;
        int   nev;
        ev_t  e;
        logic [1:0] es;
        nev = ev_q.size() - first;
        chk({nm, "_events"}, nev, NPIL + FS);
        if (nev == NPIL + FS) begin
            for (int i = 0; i < NPIL; i++) begin
                e = ev_q[first + i];
                if (e.pil !== 1'b1 || e.sym !== ((i % 2 == 0) ? 2'b11 : 2'b00) || e.idx !== '0)
                    bad_pil = bad_pil + 1;
                if (e.dn) n_dn = n_dn + 1;
            end
            for (int k = 0; k < FS; k++) begin
                e  = ev_q[first + NPIL + k];
                es = {bits_q[2*k], bits_q[2*k+1]};
                if (e.sym !== es) bad_sym = bad_sym + 1;
                if (e.idx !== IW'(k) || e.pil !== 1'b0) bad_idx = bad_idx + 1;
                if (k >= exp_cyc_q.size() || e.cyc != exp_cyc_q[k]) bad_lat = bad_lat + 1;
                if (e.dn) n_dn = n_dn + 1;
            end
            chk({nm, "_pilot_seq_bad"}, bad_pil, 0);
            chk({nm, "_payload_sym_bad"}, bad_sym, 0);
            chk({nm, "_payload_idx_bad"}, bad_idx, 0);
            chk({nm, "_latency_bad"}, bad_lat, 0);
            chk({nm, "_done_flags"}, n_dn, 1);
            chk({nm, "_done_on_last"}, ev_q[first + NPIL + FS - 1].dn, 1);
        end
    endtask

    initial begin
        // Reset dominates a same-cycle start and handshake.
        rst_i = 1'b1; start_i = 1'b1; bit_valid_i = 1'b1; bit_in_i = 1'b1;
        repeat (3) step();
        chk("rst_sym_out", sym_out_o, 0);
        chk("rst_sym_valid", sym_valid_o, 0);
        chk("rst_sym_pilot", sym_pilot_o, 0);
        chk("rst_sym_idx", sym_idx_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ready", bit_ready_o, 0);
        chk("rst_no_sym", ev_q.size(), 0);
        rst_i = 1'b0; start_i = 1'b0;

        // bit_valid in IDLE consumes nothing.
        q0 = ev_q.size();
        repeat (4) step();
        chk("idle_no_sym", ev_q.size() - q0, 0);
        chk("idle_ready", bit_ready_o, 0);
        chk("idle_busy", busy_o, 0);

        // Frame 1: continuous bits 1,0 with a start pulse mid-frame.
        bits_q.delete();
        for (int i = 0; i < FS; i++) begin bits_q.push_back(1'b1); bits_q.push_back(1'b0); end
        q0 = ev_q.size(); b0 = busy_cnt; d0 = done_cnt;
        run_frame(1'b0, 0, 300);
        step(); step();
        chk("f1_busy_cycles", busy_cnt - b0, NPIL + 2*FS + 1);
        chk("f1_done_pulses", done_cnt - d0, 1);
        chk("f1_idle_after", busy_o, 0);
        check_frame("f1", q0);
        if (ev_q.size() > q0 + NPIL) chk("f1_first_payload", ev_q[q0 + NPIL].sym, 2'b10);
        if (NPIL > 1 && ev_q.size() > q0 + 1) begin
            chk("f1_pilot0", ev_q[q0].sym, 2'b11);
            chk("f1_pilot1", ev_q[q0 + 1].sym, 2'b00);
        end

        // Frame 2: gapped valid, bits 0,1,1,1 then 1,0 pairs.
        bits_q.delete();
        bits_q.push_back(1'b0); bits_q.push_back(1'b1);
        bits_q.push_back(1'b1); bits_q.push_back(1'b1);
        for (int i = 2; i < FS; i++) begin bits_q.push_back(1'b1); bits_q.push_back(1'b0); end
        q0 = ev_q.size(); d0 = done_cnt;
        run_frame(1'b1, 0, -1);
        step(); step();
        chk("f2_done_pulses", done_cnt - d0, 1);
        check_frame("f2", q0);
        if (ev_q.size() > q0 + NPIL + 1) begin
            chk("f2_sym0", ev_q[q0 + NPIL].sym, 2'b01);
            chk("f2_sym1", ev_q[q0 + NPIL + 1].sym, 2'b11);
        end

        // Frame 3: abort by reset after 3 payload bits (a half symbol is held).
        bits_q.delete();
        for (int i = 0; i < 2*FS; i++) bits_q.push_back(1'b1);
        d0 = done_cnt;
        run_frame(1'b0, 3, -1);
        rst_i = 1'b1; start_i = 1'b1; bit_valid_i = 1'b1;
        step();
        rst_i = 1'b0; start_i = 1'b0; bit_valid_i = 1'b0;
        chk("mrst_busy", busy_o, 0);
        chk("mrst_ready", bit_ready_o, 0);
        chk("mrst_valid", sym_valid_o, 0);
        step();
        chk("mrst_no_done", done_cnt - d0, 0);

        // Frame 4: fresh frame with bits 0,0 first; stale half bit must be gone.
        bits_q.delete();
        bits_q.push_back(1'b0); bits_q.push_back(1'b0);
        for (int i = 1; i < FS; i++) begin bits_q.push_back(1'b1); bits_q.push_back(1'b0); end
        q0 = ev_q.size(); d0 = done_cnt;
        run_frame(1'b0, 0, -1);
        step(); step();
        chk("f4_done_pulses", done_cnt - d0, 1);
        check_frame("f4", q0);
        if (ev_q.size() > q0 + NPIL) begin
            chk("f4_sym0", ev_q[q0 + NPIL].sym, 2'b00);
            chk("f4_idx0", ev_q[q0 + NPIL].idx, 0);
        end

        // Pilot flag count over all four frames (zero without pilots).
        chk("pilot_flag_total", pilot_cnt, 4 * NPIL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
